// File: rtl/fan_mode_ctrl.sv
// fan_mode_ctrl: button-driven fan speed/wind mode selector with auto-off countdown timer
module fan_mode_ctrl #(
  parameter int TICK_CNT  = 100_000_000,
  parameter int WIND_STEP = 2,
  parameter int TMR_STEP  = 30
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_speed,
  input  logic       i_btn_wind,
  input  logic       i_btn_timer,
  input  logic       i_btn_off,
  output logic [5:0] o_sel,
  output logic [6:0] o_sec,
  output logic       o_timer_on,
  output logic       o_wind_on
);
  localparam int PW = TICK_CNT > 1 ? $clog2(TICK_CNT) : 1;
  localparam int WW = WIND_STEP > 1 ? $clog2(WIND_STEP) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(TICK_CNT - 1);
  localparam logic [WW-1:0] W_MAX = WW'(WIND_STEP - 1);
  localparam logic [7:0] SEC_MAX = 8'd90;
  typedef enum logic [1:0] {OFF, MANUAL, WIND} state_t;
  state_t state, state_n;
  logic [2:0] sel, sel_n;
  logic [6:0] sec, sec_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [3:0] prev, btn, press;
  logic p_off, p_spd, p_wnd, p_tmr, tick, expire;
  logic [7:0] sec_add;
  assign btn = {i_btn_off, i_btn_speed, i_btn_wind, i_btn_timer};
  assign press = btn & ~prev;
  assign {p_off, p_spd, p_wnd, p_tmr} = press;
  assign tick = (pcnt == P_MAX) && !p_tmr;
  assign expire = tick && (sec == 7'd1);
  assign pcnt_n = (p_tmr || pcnt == P_MAX) ? '0 : pcnt + PW'(1);
  assign sec_add = {1'b0, sec} + 8'(TMR_STEP);
  // state register, prescaler, wind counter and button history
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= OFF;
      sel   <= '0;
      sec   <= '0;
      pcnt  <= '0;
      wcnt  <= '0;
      prev  <= '0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      sec   <= sec_n;
      pcnt  <= pcnt_n;
      wcnt  <= wcnt_n;
      prev  <= btn;
    end
  end
  // next state: off > expiry > speed > wind > timer > wind step; countdown runs alongside
  always_comb begin
    state_n = state;
    sel_n   = sel;
    wcnt_n  = wcnt;
    sec_n   = (tick && sec != 7'd0) ? sec - 7'd1 : sec;
    if (p_off || expire || (p_spd && state == MANUAL && sel == 3'd3)) begin
      state_n = OFF;
      sel_n   = '0;
      sec_n   = '0;
      wcnt_n  = '0;
    end else if (p_spd) begin
      state_n = MANUAL;
      sel_n   = state == MANUAL ? sel + 3'd1 : 3'd1;
    end else if (p_wnd) begin
      state_n = state == WIND ? MANUAL : WIND;
      sel_n   = 3'd1;
      wcnt_n  = '0;
    end else if (p_tmr) begin
      sec_n = state == OFF ? sec : (sec_add > SEC_MAX ? 7'd0 : sec_add[6:0]);
    end else if (state == WIND && tick) begin
      wcnt_n = wcnt == W_MAX ? '0 : wcnt + WW'(1);
      sel_n  = wcnt != W_MAX ? sel : (sel == 3'd5 ? 3'd1 : sel + 3'd1);
    end
  end
  // outputs derived purely from registered state
  always_comb begin
    o_sel      = {3'b000, sel};
    o_sec      = sec;
    o_timer_on = sec != 7'd0;
    o_wind_on  = state == WIND;
  end
endmodule

// File: tb/tb_fan_mode_ctrl.sv
// tb_fan_mode_ctrl: scenario tasks plus randomized run against a behavioural fan controller model
module tb_fan_mode_ctrl;
  localparam int TICK  = 10;
  localparam int WSTEP = 2;
  localparam int TSTEP = 30;
  logic clk, rst, bs, bw, bt, bo;
  logic [5:0] o_sel;
  logic [6:0] o_sec;
  logic o_timer_on, o_wind_on;
  int checks, failures;
  int m_mode, m_sel, m_sec, m_wticks, m_since;
  logic [3:0] m_prev;

  fan_mode_ctrl #(.TICK_CNT(TICK), .WIND_STEP(WSTEP), .TMR_STEP(TSTEP)) dut (
    .i_clk(clk), .i_reset(rst), .i_btn_speed(bs), .i_btn_wind(bw),
    .i_btn_timer(bt), .i_btn_off(bo), .o_sel(o_sel), .o_sec(o_sec),
    .o_timer_on(o_timer_on), .o_wind_on(o_wind_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void m_off();
    m_mode = 0; m_sel = 0; m_sec = 0; m_wticks = 0;
  endfunction

  function automatic void m_reset();
    m_off(); m_since = 0; m_prev = '0;
  endfunction

  function automatic void m_update();
    logic po, ps, pw, pt, tk;
    po = bo & ~m_prev[3]; ps = bs & ~m_prev[2]; pw = bw & ~m_prev[1]; pt = bt & ~m_prev[0];
    m_prev = {bo, bs, bw, bt};
    tk = (m_since % TICK == TICK - 1) && !pt;
    m_since = pt ? 0 : m_since + 1;
    if (po || (tk && m_sec == 1)) m_off();
    else begin
      if (tk && m_sec > 0) m_sec--;
      if (ps) begin
        if (m_mode == 1 && m_sel == 3) m_off();
        else begin m_sel = (m_mode == 1) ? m_sel + 1 : 1; m_mode = 1; end
      end else if (pw) begin
        m_mode = (m_mode == 2) ? 1 : 2; m_sel = 1; m_wticks = 0;
      end else if (pt) begin
        if (m_mode != 0) m_sec = (m_sec + TSTEP > 90) ? 0 : m_sec + TSTEP;
      end else if (m_mode == 2 && tk) begin
        m_wticks++; m_sel = (m_wticks / WSTEP) % 5 + 1;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) m_reset(); else m_update();
    #1;
  endtask

  task automatic go_off();
    bo = 1'b1; step(); bo = 1'b0; step();
  endtask

  task automatic test_reset();
    rst = 1'b1; bs = 0; bw = 0; bt = 0; bo = 0;
    step(); step();
    checks++; if (o_sel !== 6'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", o_sel); end
    checks++; if (o_sec !== 7'd0) begin failures++; $display("FAIL reset_sec got=%0d exp=0", o_sec); end
    rst = 1'b0; step();
    checks++; if (o_timer_on !== 1'b0) begin failures++; $display("FAIL reset_timer_on got=%0b exp=0", o_timer_on); end
    checks++; if (o_wind_on !== 1'b0) begin failures++; $display("FAIL reset_wind_on got=%0b exp=0", o_wind_on); end
  endtask

  task automatic test_speed();
    int exp_sel[4] = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      bs = 1'b1; step();
      checks++; if (o_sel !== 6'(exp_sel[i])) begin failures++; $display("FAIL speed_step%0d got=%0d exp=%0d", i, o_sel, exp_sel[i]); end
      bs = 1'b0; step();
    end
    bs = 1'b1;
    for (int i = 0; i < 50; i++) step();
    checks++; if (o_sel !== 6'd1) begin failures++; $display("FAIL speed_hold got=%0d exp=1", o_sel); end
    bs = 1'b0; step();
  endtask

  task automatic test_wind();
    int t_chg[$];
    int v_chg[$];
    int last;
    go_off();
    bw = 1'b1; step(); bw = 1'b0;
    checks++; if (o_sel !== 6'd1 || o_wind_on !== 1'b1) begin failures++; $display("FAIL wind_enter got sel=%0d wind=%0b exp sel=1 wind=1", o_sel, o_wind_on); end
    last = 1;
    for (int c = 1; c <= 105; c++) begin
      step();
      checks++;
      if (o_wind_on !== 1'b1 || o_sel !== 6'(m_sel)) begin failures++; $display("FAIL wind_cycle%0d got sel=%0d wind=%0b exp sel=%0d wind=1", c, o_sel, o_wind_on, m_sel); end
      if (int'(o_sel) != last) begin t_chg.push_back(c); v_chg.push_back(int'(o_sel)); last = int'(o_sel); end
    end
    checks++; if (v_chg.size() < 5) begin failures++; $display("FAIL wind_changes got=%0d exp>=5", v_chg.size()); end
    for (int i = 0; i < 5 && i < v_chg.size(); i++) begin
      checks++; if (v_chg[i] != (i + 1) % 5 + 1) begin failures++; $display("FAIL wind_seq%0d got=%0d exp=%0d", i, v_chg[i], (i + 1) % 5 + 1); end
      if (i > 0) begin
        checks++; if (t_chg[i] - t_chg[i-1] != TICK * WSTEP) begin failures++; $display("FAIL wind_gap%0d got=%0d exp=%0d", i, t_chg[i] - t_chg[i-1], TICK * WSTEP); end
      end
    end
  endtask

  task automatic test_timer();
    int n;
    go_off();
    bs = 1'b1; step(); bs = 1'b0; step();
    bs = 1'b1; step(); bs = 1'b0; step();
    checks++; if (o_sel !== 6'd2) begin failures++; $display("FAIL timer_setup_sel got=%0d exp=2", o_sel); end
    bt = 1'b1; step(); bt = 1'b0; step(); bt = 1'b1; step(); bt = 1'b0;
    checks++; if (o_sec !== 7'd60 || o_timer_on !== 1'b1) begin failures++; $display("FAIL timer_preset got sec=%0d on=%0b exp sec=60 on=1", o_sec, o_timer_on); end
    n = 0;
    while (n < 700 && o_sec !== 7'd0) begin step(); n++; end
    checks++; if (n != 60 * TICK) begin failures++; $display("FAIL timer_expiry_cycles got=%0d exp=%0d", n, 60 * TICK); end
    checks++; if (o_sel !== 6'd0 || o_timer_on !== 1'b0) begin failures++; $display("FAIL timer_expiry_state got sel=%0d on=%0b exp sel=0 on=0", o_sel, o_timer_on); end
  endtask

  task automatic test_timer_off();
    int exp_sec[4] = '{30, 60, 90, 0};
    go_off();
    bt = 1'b1; step();
    checks++; if (o_sec !== 7'd0 || o_timer_on !== 1'b0) begin failures++; $display("FAIL timer_in_off got sec=%0d on=%0b exp sec=0 on=0", o_sec, o_timer_on); end
    bt = 1'b0; step();
    bs = 1'b1; step(); bs = 1'b0; step();
    for (int i = 0; i < 4; i++) begin
      bt = 1'b1; step();
      checks++; if (o_sec !== 7'(exp_sec[i])) begin failures++; $display("FAIL timer_preset%0d got=%0d exp=%0d", i, o_sec, exp_sec[i]); end
      bt = 1'b0; step();
    end
  endtask

  task automatic test_priority();
    for (int k = 0; k < 2; k++) begin
      go_off();
      bs = 1'b1; step(); bs = 1'b0; step();
      bt = 1'b1; step(); bt = 1'b0;
      for (int i = 0; i < 30 * TICK - 1; i++) step();
      checks++; if (o_sec !== 7'd1 || o_sel !== 6'd1) begin failures++; $display("FAIL prio%0d_pre got sec=%0d sel=%0d exp sec=1 sel=1", k, o_sec, o_sel); end
      bo = (k == 0); bs = 1'b1; step();
      checks++; if (o_sel !== 6'd0 || o_sec !== 7'd0 || o_timer_on !== 1'b0) begin failures++; $display("FAIL prio%0d_edge got sel=%0d sec=%0d exp sel=0 sec=0", k, o_sel, o_sec); end
      bo = 1'b0; bs = 1'b0; step();
      checks++; if (o_sel !== 6'd0) begin failures++; $display("FAIL prio%0d_after got sel=%0d exp=0", k, o_sel); end
    end
  endtask

  task automatic test_tick_vs_timer();
    go_off();
    bs = 1'b1; step(); bs = 1'b0; step();
    bt = 1'b1; step(); bt = 1'b0;
    for (int i = 0; i < TICK - 1; i++) step();
    bt = 1'b1; step(); bt = 1'b0;
    checks++; if (o_sec !== 7'd60) begin failures++; $display("FAIL tick_vs_press got=%0d exp=60", o_sec); end
    for (int i = 0; i < TICK - 1; i++) step();
    checks++; if (o_sec !== 7'd60) begin failures++; $display("FAIL tick_restart_hold got=%0d exp=60", o_sec); end
    step();
    checks++; if (o_sec !== 7'd59) begin failures++; $display("FAIL tick_restart_dec got=%0d exp=59", o_sec); end
  endtask

  task automatic test_async_reset();
    go_off();
    bw = 1'b1; step(); bw = 1'b0; step();
    bt = 1'b1; step(); bt = 1'b0; step(); bt = 1'b1; step(); bt = 1'b0;
    for (int i = 0; i < 15 * TICK; i++) step();
    checks++; if (o_sec !== 7'd45 || o_wind_on !== 1'b1) begin failures++; $display("FAIL areset_pre got sec=%0d wind=%0b exp sec=45 wind=1", o_sec, o_wind_on); end
    rst = 1'b1; m_reset();
    #2;
    checks++;
    if ({o_sel, o_sec, o_timer_on, o_wind_on} !== 15'd0) begin
      failures++; $display("FAIL areset_immediate got sel=%0d sec=%0d on=%0b wind=%0b exp all 0", o_sel, o_sec, o_timer_on, o_wind_on);
    end
    step(); step(); rst = 1'b0; step();
    bs = 1'b1; step(); bs = 1'b0;
    checks++; if (o_sel !== 6'd1) begin failures++; $display("FAIL areset_first_speed got=%0d exp=1", o_sel); end
    step();
  endtask

  task automatic test_random();
    logic [14:0] exp_v;
    int div;
    for (int blk = 0; blk < 8; blk++) begin
      div = blk[0] ? 150 : 6;
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(div - 1) == 0) bs = ~bs;
        if ($urandom_range(div * 2 - 1) == 0) bw = ~bw;
        if ($urandom_range(div + 1) == 0) bt = ~bt;
        if ($urandom_range(div * 5 - 1) == 0) bo = ~bo;
        step();
        exp_v = {6'(m_sel), 7'(m_sec), m_sec != 0, m_mode == 2};
        checks++;
        if ({o_sel, o_sec, o_timer_on, o_wind_on} !== exp_v || o_sel > 6'd5 || o_sec > 7'd90) begin
          failures++;
          $display("FAIL random blk%0d cyc%0d got sel=%0d sec=%0d on=%0b wind=%0b exp sel=%0d sec=%0d on=%0b wind=%0b",
                   blk, c, o_sel, o_sec, o_timer_on, o_wind_on, exp_v[14:9], exp_v[8:2], exp_v[1], exp_v[0]);
        end
      end
    end
    bs = 0; bw = 0; bt = 0; bo = 0; step();
  endtask

  initial begin
    checks = 0; failures = 0;
    m_reset();
    test_reset();
    test_speed();
    test_wind();
    test_timer();
    test_timer_off();
    test_priority();
    test_tick_vs_timer();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
